dsp_add: RTL and testbench

DSP_ADD -- requirements
Module: dsp_add

---
 rtl/dsp_pkg.sv | 12 +
 rtl/dsp_alu48.sv | 35 +++
 rtl/dsp_add.sv | 84 ++++++++
 tb/tb_dsp_add.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: datapath width, SIMD lane width and the SIMD
// mode selector used by the 48-bit adder core.
package dsp_pkg;
  localparam int DSP_WIDTH  = 48;
  localparam int LANE_WIDTH = 24;

  // ONE48: a single 48-bit add. TWO24: two independent 24-bit adds.
  typedef enum logic {
    ONE48 = 1'b0,
    TWO24 = 1'b1
  } simd_mode_e;
endpackage

// File: rtl/dsp_alu48.sv
// 48-bit registered adder with optional split into two 24-bit SIMD lanes.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-low; clears y
//   mode  - ONE48 (full carry chain) or TWO24 (carry cut between bit 23/24)
//   a, b  - 48-bit addends
//   y     - registered sum, one cycle latency
module dsp_alu48
  import dsp_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  simd_mode_e           mode,
  input  logic [DSP_WIDTH-1:0] a,
  input  logic [DSP_WIDTH-1:0] b,
  output logic [DSP_WIDTH-1:0] y
);
  logic [LANE_WIDTH:0]   lo_sum;
  logic                  lo_carry;
  logic [LANE_WIDTH-1:0] hi_sum;

  assign lo_sum = {1'b0, a[LANE_WIDTH-1:0]} + {1'b0, b[LANE_WIDTH-1:0]};

  // The low-lane carry feeds the high lane only when running as one 48-bit add.
  assign lo_carry = (mode == ONE48) & lo_sum[LANE_WIDTH];

  // Carry out of bit 47 falls off the 24-bit result: modular wrap.
  assign hi_sum = a[DSP_WIDTH-1:LANE_WIDTH] + b[DSP_WIDTH-1:LANE_WIDTH]
                + LANE_WIDTH'(lo_carry);

  always_ff @(posedge clock) begin
    if (!reset) y <= '0;
    else        y <= {hi_sum, lo_sum[LANE_WIDTH-1:0]};
  end
endmodule

// File: rtl/dsp_add.sv
// dsp_add: registered modular adder, y = (a + b) mod 2^width, 1-cycle latency.
//   Ports: clock, reset (sync, active-low), a, b (width bits), y (width bits).
//   width legal range 1..48.
// dsp_add_v2: two independent registered adders sharing one 48-bit core
//   split into 24-bit lanes. y = (a + b) mod 2^width, z = (c + d) mod 2^width.
//   Ports: clock, reset, a, b, c, d (width bits), y, z (width bits).
//   width legal range 1..24.
module dsp_add
  import dsp_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] y
);
  logic [DSP_WIDTH-1:0] a_ext;
  logic [DSP_WIDTH-1:0] b_ext;
  logic [DSP_WIDTH-1:0] sum;

  // Zero-extend: bits above width-1 never reach y, so sign handling is moot.
  assign a_ext = DSP_WIDTH'(a);
  assign b_ext = DSP_WIDTH'(b);

  dsp_alu48 u_alu (
    .clock (clock),
    .reset (reset),
    .mode  (ONE48),
    .a     (a_ext),
    .b     (b_ext),
    .y     (sum)
  );

  assign y = sum[width-1:0];

  // Carry-out and upper bits are intentionally discarded.
  if (width < DSP_WIDTH) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^sum[DSP_WIDTH-1:width];
  end
endmodule

module dsp_add_v2
  import dsp_pkg::*;
#(
  parameter int width = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic [width-1:0] c,
  input  logic [width-1:0] d,
  output logic [width-1:0] y,
  output logic [width-1:0] z
);
  logic [DSP_WIDTH-1:0] op_a;
  logic [DSP_WIDTH-1:0] op_b;
  logic [DSP_WIDTH-1:0] sum;

  // Low lane carries a/b, high lane carries c/d; each zero-extended to 24.
  assign op_a = {LANE_WIDTH'(c), LANE_WIDTH'(a)};
  assign op_b = {LANE_WIDTH'(d), LANE_WIDTH'(b)};

  dsp_alu48 u_alu (
    .clock (clock),
    .reset (reset),
    .mode  (TWO24),
    .a     (op_a),
    .b     (op_b),
    .y     (sum)
  );

  assign y = sum[width-1:0];
  assign z = sum[LANE_WIDTH+width-1:LANE_WIDTH];

  if (width < LANE_WIDTH) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{sum[DSP_WIDTH-1:LANE_WIDTH+width],
                         sum[LANE_WIDTH-1:width]};
  end
endmodule

// File: tb/tb_dsp_add.sv
// Directed bench for dsp_add (widths 8, 32, 48) and dsp_add_v2 (width 24).
module tb_dsp_add;
  logic clock = 1'b0;
  logic reset;

  logic [7:0]  a8,  b8,  y8;
  logic [31:0] a32, b32, y32;
  logic [47:0] a48, b48, y48;
  logic [23:0] va, vb, vc, vd, vy, vz;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dsp_add #(.width(8)) dut (
    .clock (clock), .reset (reset), .a (a8), .b (b8), .y (y8)
  );
  dsp_add #(.width(32)) dut32 (
    .clock (clock), .reset (reset), .a (a32), .b (b32), .y (y32)
  );
  dsp_add #(.width(48)) dut48 (
    .clock (clock), .reset (reset), .a (a48), .b (b48), .y (y48)
  );
  dsp_add_v2 #(.width(24)) dutv2 (
    .clock (clock), .reset (reset),
    .a (va), .b (vb), .c (vc), .d (vd), .y (vy), .z (vz)
  );

  // Inputs change on the falling edge; outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    a8 = 8'h12; b8 = 8'h34; a32 = 32'h1; b32 = 32'h2;
    a48 = 48'h5; b48 = 48'h6; va = 24'h1; vb = 24'h2; vc = 24'h3; vd = 24'h4;
    step();
    checks++;
    if (y8 !== 8'h00) begin errors++; $display("FAIL reset_y8 got %h exp 00", y8); end
    checks++;
    if (y32 !== 32'h0) begin errors++; $display("FAIL reset_y32 got %h exp 0", y32); end
    checks++;
    if (y48 !== 48'h0) begin errors++; $display("FAIL reset_y48 got %h exp 0", y48); end
    checks++;
    if (vy !== 24'h0 || vz !== 24'h0) begin
      errors++; $display("FAIL reset_v2 got y=%h z=%h exp 0/0", vy, vz);
    end
  endtask

  // 0xFF + 0x10 wraps to 0x0F on the first edge after release, then holds.
  task automatic test_wrap8();
    @(negedge clock);
    a8 = 8'hFF; b8 = 8'h10;
    step();
    checks++;
    if (y8 !== 8'h00) begin errors++; $display("FAIL wrap8_in_reset got %h exp 00", y8); end
    @(negedge clock);
    reset = 1'b1;
    step();
    checks++;
    if (y8 !== 8'h0F) begin errors++; $display("FAIL wrap8_first got %h exp 0f", y8); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (y8 !== 8'h0F) begin errors++; $display("FAIL wrap8_hold%0d got %h exp 0f", i, y8); end
    end
  endtask

  task automatic test_width32();
    @(negedge clock);
    a32 = 32'h0000_0001; b32 = 32'hFFFF_0001;
    step();
    checks++;
    if (y32 !== 32'hFFFF_0002) begin
      errors++; $display("FAIL add32 got %h exp ffff0002", y32);
    end
    @(negedge clock);
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0003;
    step();
    checks++;
    if (y32 !== 32'h0000_0002) begin
      errors++; $display("FAIL wrap32 got %h exp 00000002", y32);
    end
  endtask

  task automatic test_width48();
    @(negedge clock);
    a48 = 48'hFFFF_FFFF_FFFF; b48 = 48'h1;
    step();
    checks++;
    if (y48 !== 48'h0) begin errors++; $display("FAIL wrap48 got %h exp 0", y48); end
    // Carry must cross the 24-bit lane boundary in single-add mode.
    @(negedge clock);
    a48 = 48'h0000_00FF_FFFF; b48 = 48'h1;
    step();
    checks++;
    if (y48 !== 48'h0000_0100_0000) begin
      errors++; $display("FAIL carry48 got %h exp 000001000000", y48);
    end
  endtask

  task automatic test_v2_lanes();
    @(negedge clock);
    va = 24'hFFFFFF; vb = 24'h000010; vc = 24'd23; vd = 24'd7;
    step();
    checks++;
    if (vy !== 24'h00000F) begin errors++; $display("FAIL v2_y got %h exp 00000f", vy); end
    checks++;
    if (vz !== 24'd30) begin errors++; $display("FAIL v2_z got %0d exp 30", vz); end
    // Lane y carries out while lane z sits at all ones: a leaked carry would zero z.
    @(negedge clock);
    va = 24'hFFFFFF; vb = 24'h000001; vc = 24'hFFFFFF; vd = 24'h000000;
    step();
    checks++;
    if (vy !== 24'h0 || vz !== 24'hFFFFFF) begin
      errors++; $display("FAIL v2_isolate got y=%h z=%h exp 000000/ffffff", vy, vz);
    end
    // Lane z wrap must not show up in lane y either.
    @(negedge clock);
    va = 24'h000005; vb = 24'h000006; vc = 24'hFFFFFE; vd = 24'h000003;
    step();
    checks++;
    if (vy !== 24'd11 || vz !== 24'h000001) begin
      errors++; $display("FAIL v2_zwrap got y=%h z=%h exp 00000b/000001", vy, vz);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clock);
    a8 = 8'd5; b8 = 8'd6;
    step();
    checks++;
    if (y8 !== 8'd11) begin errors++; $display("FAIL midrst_pre got %0d exp 11", y8); end
    @(negedge clock);
    reset = 1'b0;
    step();
    checks++;
    if (y8 !== 8'd0) begin errors++; $display("FAIL midrst_clear got %0d exp 0", y8); end
    @(negedge clock);
    reset = 1'b1;
    checks++;
    if (y8 !== 8'd0) begin errors++; $display("FAIL midrst_hold got %0d exp 0", y8); end
    step();
    checks++;
    if (y8 !== 8'd11) begin errors++; $display("FAIL midrst_release got %0d exp 11", y8); end
  endtask

  // New operands every cycle; each result appears one edge later and is
  // still the previous value just before that edge.
  task automatic test_back_to_back();
    logic [7:0] prev;
    prev = 8'd11;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      a8 = 8'(i); b8 = 8'd10;
      #1;
      checks++;
      if (y8 !== prev) begin
        errors++; $display("FAIL b2b_before%0d got %0d exp %0d", i, y8, prev);
      end
      step();
      checks++;
      if (y8 !== 8'(10 + i)) begin
        errors++; $display("FAIL b2b_after%0d got %0d exp %0d", i, y8, 10 + i);
      end
      prev = 8'(10 + i);
    end
  endtask

  initial begin
    reset = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0; a48 = '0; b48 = '0;
    va = '0; vb = '0; vc = '0; vd = '0;
    test_reset();
    test_wrap8();
    test_width32();
    test_width48();
    test_v2_lanes();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
